// File: rtl/modexp_1409_pkg.sv
// Shared constants and FSM state encoding for the modulo-1409 exponentiator.
package modexp_1409_pkg;

    localparam int unsigned Q_MOD  = 1409;
    localparam int unsigned OP_W   = 11;
    localparam int unsigned PROD_W = 21;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL,
        SQR,
        DONE
    } state_t;

endpackage

// File: rtl/barret_for_1409.sv
// Combinational Barrett reduction of a 21-bit value modulo 1409.
module barret_for_1409
    import modexp_1409_pkg::*;
(
    input  logic [PROD_W-1:0] din_a,
    output logic [OP_W-1:0]   dout_r
);

    // With k = 21 and m = floor(2^21 / 1409), the quotient estimate is never
    // more than one short, so a single conditional subtraction finishes the job.
    localparam int unsigned K_SHIFT = 21;
    localparam int unsigned M_RECIP = (1 << K_SHIFT) / Q_MOD;
    localparam int unsigned MW      = PROD_W + OP_W;

    logic [MW-1:0]   prod_m;
    logic [OP_W-1:0] q_est;
    logic [OP_W:0]   q_times;
    logic [OP_W:0]   rem;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        prod_m  = MW'(din_a) * MW'(M_RECIP);
        q_est   = OP_W'(prod_m >> K_SHIFT);
        q_times = (OP_W+1)'(q_est) * (OP_W+1)'(Q_MOD);
        rem     = din_a[OP_W:0] - q_times;
        dout_r  = (rem >= (OP_W+1)'(Q_MOD)) ? OP_W'(rem - (OP_W+1)'(Q_MOD)) : rem[OP_W-1:0];
    end

endmodule

// File: rtl/modexp_1409.sv
// Right-to-left square-and-multiply base^exp mod 1409 with fixed latency.
module modexp_1409
    import modexp_1409_pkg::*;
#(
    parameter int Q     = 1409,
    parameter int EXP_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  base,
    input  logic [EXP_W-1:0] exp,
    output logic             busy,
    output logic             done,
    output logic [OP_W-1:0]  result
);

    localparam int CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    // The reducer is hard-wired to 1409; any other modulus is a build error.
    if (Q != Q_MOD) begin : g_bad_q
        $error("modexp_1409 supports only Q = 1409");
    end

    state_t            state, state_next;
    logic [OP_W-1:0]   base_q;
    logic [EXP_W-1:0]  exp_q;
    logic [OP_W-1:0]   acc;
    logic [OP_W-1:0]   b;
    logic [CNT_W-1:0]  bitcnt;

    logic [OP_W-1:0]   mul_a;
    logic [PROD_W-1:0] product;
    logic [PROD_W-1:0] red_in;
    logic [OP_W-1:0]   red_out;

    // One multiplier and one reducer, shared by LOAD, MUL and SQR.
    always_comb begin
        mul_a   = (state == MUL) ? acc : b;
        product = PROD_W'(mul_a) * PROD_W'(b);
        red_in  = (state == LOAD) ? PROD_W'(base_q) : product;
    end

    barret_for_1409 u_reduce (
        .din_a  (red_in),
        .dout_r (red_out)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = MUL;
            MUL:  state_next = SQR;
            SQR:  state_next = (bitcnt == CNT_W'(EXP_W - 1)) ? DONE : MUL;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            base_q <= '0;
            exp_q  <= '0;
            acc    <= '0;
            b      <= '0;
            bitcnt <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
            // acc is final once the last SQR begins, so capture it entering DONE.
            if (state_next == DONE) result <= acc;
            case (state)
                IDLE: if (start) begin
                    base_q <= base;
                    exp_q  <= exp;
                    acc    <= OP_W'(1);
                    bitcnt <= '0;
                end
                LOAD: b <= red_out;
                MUL:  if (exp_q[bitcnt]) acc <= red_out;
                SQR: begin
                    b      <= red_out;
                    bitcnt <= bitcnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_1409.sv
// Self-checking bench for modexp_1409: per-cycle model comparison plus directed cases.
module tb_modexp_1409;

    localparam int Q     = 1409;
    localparam int EXP_W = 11;
    localparam int LAT   = 2 * EXP_W + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [10:0]      base;
    logic [EXP_W-1:0] exp;
    logic             busy;
    logic             done;
    logic [10:0]      result;

    int errors = 0;
    int checks = 0;

    modexp_1409 #(.Q(Q), .EXP_W(EXP_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .base   (base),
        .exp    (exp),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Reference: repeated multiplication, no square-and-multiply.
    function automatic int modpow(input int bv, input int ev);
        longint r  = 1;
        longint bb = longint'(bv % Q);
        for (int i = 0; i < ev; i++) r = (r * bb) % Q;
        return int'(r);
    endfunction

    // Behavioural model: an accepted request makes busy true for LAT cycles and
    // shows done plus the answer in the last one; a reset wipes everything.
    bit m_valid = 1'b0;
    bit m_active;
    int m_cnt;
    int m_pending;
    bit m_busy;
    bit m_done;
    int m_result;
    bit s_rst, s_start;
    int s_base, s_exp;

    always @(posedge clk) begin
        s_rst   = (rst === 1'b1);
        s_start = (start === 1'b1);
        s_base  = int'(base);
        s_exp   = int'(exp);
        if (s_rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_cnt    = 0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_result = 0;
        end else if (m_valid) begin
            m_done = 1'b0;
            if (m_active) begin
                m_cnt++;
                if (m_cnt == LAT) begin
                    m_done   = 1'b1;
                    m_result = m_pending;
                end else if (m_cnt == LAT + 1) begin
                    m_active = 1'b0;
                    m_busy   = 1'b0;
                end
            end else if (s_start) begin
                m_active  = 1'b1;
                m_cnt     = 1;
                m_busy    = 1'b1;
                m_pending = modpow(s_base, s_exp);
            end
        end
        #1;
        if (m_valid) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("result", result, m_result);
        end
    end

    // Called at the negedge of the first cycle after acceptance; returns at the
    // negedge of the done cycle, scrambling operands meanwhile.
    task automatic wait_done(output int res, output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < LAT + 10) begin
            base = 11'($urandom);
            exp  = EXP_W'($urandom);
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) check("done_timeout", 0, 1);
        res = int'(result);
    endtask

    task automatic run_op(input int bv, input int ev, output int res, output int lat);
        @(negedge clk);
        base  = 11'(bv);
        exp   = EXP_W'(ev);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(res, lat);
    endtask

    int r, l, ndone;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        exp   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("model_2_10", modpow(2, 10), 1024);
        check("model_3_1408", modpow(3, 1408), 1);
        check("model_1408_3", modpow(1408, 3), 1408);
        check("model_2_11", modpow(2, 11), 639);
        check("model_1410_5", modpow(1410, 5), 1);

        run_op(2, 10, r, l);
        check("r_2_10", r, 1024);
        check("lat_2_10", l, LAT);
        run_op(3, 1408, r, l);
        check("r_3_1408", r, 1);
        run_op(1408, 3, r, l);
        check("r_1408_3", r, 1408);
        run_op(2, 11, r, l);
        check("r_2_11", r, 639);
        run_op(0, 0, r, l);
        check("r_0_0", r, 1);
        run_op(1410, 5, r, l);
        check("r_1410_5", r, 1);
        run_op(0, 7, r, l);
        check("r_0_7", r, 0);
        run_op(2047, 2047, r, l);
        check("r_2047_2047", r, modpow(2047, 2047));

        // start held high with fresh operands through the whole run, DONE included
        @(negedge clk);
        base  = 11'd2;
        exp   = EXP_W'(10);
        start = 1'b1;
        @(negedge clk);
        l = 1;
        while (done !== 1'b1 && l < LAT + 10) begin
            base = 11'($urandom);
            exp  = EXP_W'($urandom);
            @(negedge clk);
            l++;
        end
        check("busy_restart_r", result, 1024);
        check("busy_restart_lat", l, LAT);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("no_extra_done", ndone, 0);

        // reset in the middle of a run, then immediate restart
        @(negedge clk);
        base  = 11'd7;
        exp   = EXP_W'(100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        base  = 11'd5;
        exp   = EXP_W'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(r, l);
        check("r_5_2", r, 25);
        check("lat_5_2", l, LAT);

        for (int i = 0; i < 2000; i++) begin
            int bv, ev;
            bv = int'($urandom_range(0, 2047));
            ev = int'($urandom_range(0, 2047));
            run_op(bv, ev, r, l);
            check("sweep_range", (r < Q) ? 1 : 0, 1);
            check("sweep_value", r, modpow(bv, ev));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
